ram_scanner: RTL and testbench
==============================

# ram_scanner

Autonomous read-side companion to the 16×8 switch-written register file. It walks every address in order and holds each entry for a programmable dwell time so the 7-segment digits can show it. It keeps a running 8-bit checksum of the walked contents and supports pause/single-step. It sits between the register file read port (addr/dout) and the bcd7seg display decoders, and it replaces the manual SW[3:0] address selection when scan mode is active.

## Interface

Parameters:
- ADDR_W, 4, address width; the scan covers 2^ADDR_W entries.
- DATA_W, 8, data width of the register file.
- DWELL, 4, cycles each address is held before capture; legal range is DWELL ≥ 1.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle pulse that begins or restarts a scan.
- pause  input  1  level; while high, the dwell counter is frozen.
- step  input  1  one-cycle pulse; only acts in PAUSE.
- loop  input  1  level; when high, the scan wraps after the last entry instead of stopping.
- rd_addr  output  ADDR_W  address driven to the register file read port.
- rd_data  input  DATA_W  register file read data; combinational from rd_addr in the same cycle.
- disp_addr  output  ADDR_W  address of the last captured entry.
- disp_data  output  DATA_W  data of the last captured entry; drives the bcd7seg instances.
- disp_valid  output  1  one-cycle pulse when disp_addr/disp_data update.
- checksum  output  DATA_W  sum mod 2^DATA_W of all entries in the last completed pass.
- done  output  1  one-cycle pulse when a pass completes.
- busy  output  1  high in SCAN or PAUSE.

## Operation

- States: IDLE, SCAN, PAUSE, DONE. Reset enters IDLE.
- Internal registers: dwell_cnt (width ≥ clog2(DWELL)) and acc (DATA_W).
- Capture event (C):
  - disp_addr ← rd_addr, disp_data ← rd_data, acc ← acc + rd_data (mod 2^DATA_W).
  - disp_valid = 1 in the following cycle.
  - dwell_cnt ← 0, rd_addr ← rd_addr + 1.
- If C occurs at rd_addr = 2^ADDR_W−1:
  - checksum ← acc + rd_data; acc ← 0; done pulses in the following cycle.
  - rd_addr wraps to 0.
  - With loop = 1 the block stays in SCAN; otherwise it goes to DONE.
- IDLE: rd_addr = 0, busy = 0. On start → SCAN with dwell_cnt = 0 and acc = 0.
- SCAN:
  - dwell_cnt increments each cycle.
  - C fires in the cycle where dwell_cnt == DWELL−1.
  - pause = 1 → PAUSE at the next edge. If C fires in that same cycle, C still completes.
- PAUSE:
  - dwell_cnt and rd_addr hold.
  - A step pulse fires C immediately, independent of dwell_cnt. If this completes the pass, the end-of-pass rule above applies, except the state stays PAUSE unless loop = 0, in which case it goes to DONE.
  - pause = 0 → SCAN, resuming from the held dwell_cnt.
- DONE: outputs hold, busy = 0. start → SCAN from address 0.
- Priority: start > pause > step.
  - start in any state restarts: rd_addr ← 0, dwell_cnt ← 0, acc ← 0, state ← SCAN.
  - checksum, disp_addr and disp_data keep their old values until overwritten.
- step outside PAUSE is ignored. pause in IDLE or DONE is ignored.

## Timing

- Reset values: rd_addr 0, disp_addr 0, disp_data 0, disp_valid 0, checksum 0, done 0, busy 0, dwell_cnt 0, acc 0.
- rst_n asserted mid-scan clears everything immediately (asynchronous), with no pulse on done or disp_valid. Release is synchronous to clk.
- busy is high from the cycle after start is sampled.
- Free-running latency:
  - First disp_valid comes DWELL cycles after start is sampled.
  - A full pass takes 2^ADDR_W × DWELL cycles.
  - done coincides with the final disp_valid.
- DWELL = 1: one capture per cycle with back-to-back disp_valid pulses.
- All outputs are registered. rd_addr is stable for a whole cycle before its capture edge.

## Test plan

- **Free scan, DWELL=4, loop=0.** Preload mem[i] = i×3 and pulse start.
  - Required: 16 disp_valid pulses at 4-cycle spacing with disp_data = 0,3,…,45.
  - done pulses once, checksum = 0x68 (360 mod 256), state = DONE, busy = 0.
- **Loop mode, all entries 0xFF.** Run two passes.
  - Required: done pulses every 64 cycles, checksum = 0xF0 after each pass, rd_addr wraps 15→0.
- **Pause and step.** Assert pause at cycle 6, then give 3 step pulses spaced 5 cycles apart.
  - Required: exactly 3 disp_valid pulses, addresses increment by one per step, no captures between steps.
  - After pause drops, dwell resumes from 0.
- **Simultaneous pause with dwell expiry.**
  - Required: capture still occurs, the state becomes PAUSE, and rd_addr has already advanced.
- **Restart and reset mid-scan.**
  - start at address 9: the next capture is at address 0, acc is restarted, and checksum keeps its old value.
  - rst_n low at address 5: all outputs are 0 within the same cycle, with no done pulse.
- **DWELL=1.**
  - Required: disp_valid high for 16 consecutive cycles, then the done pulse on the 16th cycle.

Source files
------------

// File: rtl/ram_scanner.sv
// Read-side scanner for the switch-written register file: walks every address,
// holds each for DWELL cycles, publishes it to the display and keeps a per-pass checksum.
module ram_scanner #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DWELL  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pause,
   input  logic              step,
   input  logic              loop,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic [DATA_W-1:0] checksum,
   output logic              done,
   output logic              busy
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_dwell_cnt;
   logic [DATA_W-1:0] r_acc;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_disp_addr;
   logic [DATA_W-1:0] r_disp_data;
   logic              r_disp_valid;
   logic [DATA_W-1:0] r_checksum;
   logic              r_done;
   logic              r_busy;

   logic [1:0]        w_state_next;
   logic [CNT_W-1:0]  w_dwell_next;
   logic              w_cap;
   logic              w_last;
   logic [DATA_W-1:0] w_sum;

   // start outranks everything, so a capture due on the restart edge is dropped
   assign w_cap  = !start && (((r_state == S_SCAN) && (r_dwell_cnt == DWELL_LAST)) ||
                              ((r_state == S_PAUSE) && pause && step));
   assign w_last = (r_rd_addr == ADDR_LAST);
   assign w_sum  = r_acc + rd_data;

   always_comb begin
      w_state_next = r_state;
      w_dwell_next = r_dwell_cnt;
      if (start) begin
         w_state_next = S_SCAN;
         w_dwell_next = '0;
      end else begin
         case (r_state)
            S_SCAN: begin
               if (w_cap)
                  w_dwell_next = '0;
               else if (!pause)
                  w_dwell_next = r_dwell_cnt + 1'b1;
               if (w_cap && w_last && !loop)
                  w_state_next = S_DONE;
               else if (pause)
                  w_state_next = S_PAUSE;
            end
            S_PAUSE: begin
               if (!pause) begin
                  w_state_next = S_SCAN;
               end else if (w_cap) begin
                  w_dwell_next = '0;
                  if (w_last && !loop)
                     w_state_next = S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_dwell_cnt  <= '0;
         r_acc        <= '0;
         r_rd_addr    <= '0;
         r_disp_addr  <= '0;
         r_disp_data  <= '0;
         r_disp_valid <= 1'b0;
         r_checksum   <= '0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_dwell_cnt  <= w_dwell_next;
         r_disp_valid <= w_cap;
         r_done       <= w_cap && w_last;
         r_busy       <= (w_state_next == S_SCAN) || (w_state_next == S_PAUSE);
         if (start) begin
            r_rd_addr <= '0;
            r_acc     <= '0;
         end else if (w_cap) begin
            // address wraps naturally after the last entry
            r_rd_addr   <= r_rd_addr + 1'b1;
            r_disp_addr <= r_rd_addr;
            r_disp_data <= rd_data;
            if (w_last) begin
               r_checksum <= w_sum;
               r_acc      <= '0;
            end else begin
               r_acc <= w_sum;
            end
         end
      end
   end

   assign rd_addr    = r_rd_addr;
   assign disp_addr  = r_disp_addr;
   assign disp_data  = r_disp_data;
   assign disp_valid = r_disp_valid;
   assign checksum   = r_checksum;
   assign done       = r_done;
   assign busy       = r_busy;

endmodule

// File: tb/tb_ram_scanner.sv
// Bench for ram_scanner: random register contents, captures and pass-ends logged
// by a monitor and compared against expectations computed from the scan rules.
module tb_ram_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, pause, step, loop;
   logic [3:0] rd_addr, disp_addr;
   logic [7:0] rd_data, disp_data, checksum;
   logic       disp_valid, done, busy;

   logic       start1, loop1;
   logic [3:0] rd_addr1, disp_addr1;
   logic [7:0] rd_data1, disp_data1, checksum1;
   logic       disp_valid1, done1, busy1;

   logic [7:0] mem  [16];
   logic [7:0] mem1 [16];
   assign rd_data  = mem[rd_addr];
   assign rd_data1 = mem1[rd_addr1];

   ram_scanner #(.ADDR_W(4), .DATA_W(8), .DWELL(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .step(step), .loop(loop),
      .rd_addr(rd_addr), .rd_data(rd_data), .disp_addr(disp_addr), .disp_data(disp_data),
      .disp_valid(disp_valid), .checksum(checksum), .done(done), .busy(busy));

   ram_scanner #(.ADDR_W(4), .DATA_W(8), .DWELL(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .pause(1'b0), .step(1'b0), .loop(loop1),
      .rd_addr(rd_addr1), .rd_data(rd_data1), .disp_addr(disp_addr1), .disp_data(disp_data1),
      .disp_valid(disp_valid1), .checksum(checksum1), .done(done1), .busy(busy1));

   typedef struct {int cyc; int addr; int data;} ev_t;
   ev_t capq[$], doneq[$], cap1q[$], done1q[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (disp_valid)  capq.push_back('{cyc, int'(disp_addr), int'(disp_data)});
      if (done)        doneq.push_back('{cyc, 0, int'(checksum)});
      if (disp_valid1) cap1q.push_back('{cyc, int'(disp_addr1), int'(disp_data1)});
      if (done1)       done1q.push_back('{cyc, 0, int'(checksum1)});
   end

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ts = the edge on which start is sampled
   task automatic pulse_start(output int ts);
      start = 1'b1;
      tick();
      start = 1'b0;
      ts = cyc;
      capq.delete();
      doneq.delete();
   endtask

   function automatic int sum_mem(input int use1);
      int s = 0;
      for (int k = 0; k < 16; k++) s += (use1 != 0) ? int'(mem1[k]) : int'(mem[k]);
      return s % 256;
   endfunction

   // entry k of a free-running pass is captured dw*(k+1) cycles after t0
   task automatic chk_caps(input string tag, input int base, input int n, input int t0,
                           input int dw, input int use1);
      ev_t e;
      int  sz;
      sz = (use1 != 0) ? cap1q.size() : capq.size();
      if (sz < base + n) begin
         chk({tag, "_count"}, sz, base + n);
      end else begin
         for (int k = 0; k < n; k++) begin
            e = (use1 != 0) ? cap1q[base + k] : capq[base + k];
            chk($sformatf("%s_addr%0d", tag, k), e.addr, k);
            chk($sformatf("%s_data%0d", tag, k), e.data,
                (use1 != 0) ? int'(mem1[k]) : int'(mem[k]));
            chk($sformatf("%s_cyc%0d", tag, k), e.cyc, t0 + dw * (k + 1));
         end
      end
   endtask

   int ts, ts2, n, exp_ck;
   int e_step [3];

   initial begin
      rst_n = 1'b0; start = 0; pause = 0; step = 0; loop = 0; start1 = 0; loop1 = 0;
      for (int i = 0; i < 16; i++) begin
         mem[i] = '0;
         mem1[i] = '0;
      end
      tick(2);
      chk("reset_outputs", {rd_addr, disp_addr, disp_data, disp_valid, checksum, done, busy}, 0);
      chk("reset_outputs_d1", {rd_addr1, disp_addr1, disp_data1, disp_valid1, checksum1, done1, busy1}, 0);
      rst_n = 1'b1;
      tick(2);

      // free scan: fixed i*3 pattern, then random contents
      for (int run = 0; run < 2; run++) begin
         for (int i = 0; i < 16; i++) mem[i] = (run == 0) ? 8'(i * 3) : 8'($urandom_range(0, 255));
         pulse_start(ts);
         chk("free_busy_after_start", busy, 1);
         tick(70);
         chk_caps($sformatf("free%0d", run), 0, 16, ts, 4, 0);
         chk("free_cap_total", capq.size(), 16);
         chk("free_done_count", doneq.size(), 1);
         if (doneq.size() > 0) begin
            chk("free_done_cyc", doneq[0].cyc, ts + 64);
            chk("free_done_ck", doneq[0].data, sum_mem(0));
         end
         if (run == 0) chk("free_ck_0x68", checksum, 8'h68);
         chk("free_busy_end", busy, 0);
         chk("free_rdaddr_end", rd_addr, 0);
         exp_ck = sum_mem(0);
      end

      // loop mode with all 0xFF: a pass every 64 cycles
      for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
      loop = 1'b1;
      pulse_start(ts);
      tick(130);
      chk("loop_done_count", doneq.size(), 2);
      for (int p = 0; p < 2 && p < doneq.size(); p++) begin
         chk($sformatf("loop_done_cyc%0d", p), doneq[p].cyc, ts + 64 * (p + 1));
         chk($sformatf("loop_done_ck%0d", p), doneq[p].data, 8'hF0);
      end
      chk_caps("loop_pass2", 16, 16, ts + 64, 4, 0);
      chk("loop_busy", busy, 1);
      loop = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("loop_stop_busy", busy, 0);
      exp_ck = 8'hF0;

      // pause at cycle 6, three steps 5 cycles apart, then resume
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      pulse_start(ts);
      tick(5);
      pause = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) begin
         tick(4);
         step = 1'b1;
         tick();
         step = 1'b0;
         e_step[s] = cyc;
      end
      tick(3);
      pause = 1'b0;
      tick();
      ts2 = cyc;
      tick(3);
      chk("pause_no_early_resume", capq.size(), 4);
      tick(2);
      chk("pause_cap_count", capq.size(), 5);
      if (capq.size() >= 5) begin
         chk("pause_c0_cyc", capq[0].cyc, ts + 4);
         chk("pause_c0_addr", capq[0].addr, 0);
         for (int s = 0; s < 3; s++) begin
            chk($sformatf("step%0d_cyc", s), capq[s + 1].cyc, e_step[s]);
            chk($sformatf("step%0d_addr", s), capq[s + 1].addr, s + 1);
            chk($sformatf("step%0d_data", s), capq[s + 1].data, mem[s + 1]);
         end
         chk("resume_cyc", capq[4].cyc, ts2 + 4);
         chk("resume_addr", capq[4].addr, 4);
      end
      chk("pause_rdaddr", rd_addr, 5);

      // pause raised on the same edge the dwell expires
      pulse_start(ts);
      tick(3);
      pause = 1'b1;
      tick();
      tick(8);
      chk("simul_cap_count", capq.size(), 1);
      if (capq.size() >= 1) chk("simul_cap_cyc", capq[0].cyc, ts + 4);
      chk("simul_rdaddr", rd_addr, 1);
      chk("simul_busy", busy, 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      n = cyc;
      tick();
      chk("simul_step_count", capq.size(), 2);
      if (capq.size() >= 2) begin
         chk("simul_step_cyc", capq[1].cyc, n);
         chk("simul_step_addr", capq[1].addr, 1);
      end
      pause = 1'b0;

      // restart at address 9
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      pulse_start(ts);
      tick(37);
      chk("restart_rdaddr_before", rd_addr, 9);
      start = 1'b1;
      tick();
      start = 1'b0;
      ts2 = cyc;
      chk("restart_ck_kept", checksum, exp_ck);
      tick(70);
      chk_caps("restart_pre", 0, 9, ts, 4, 0);
      chk_caps("restart_post", 9, 16, ts2, 4, 0);
      chk("restart_cap_total", capq.size(), 25);
      chk("restart_done_count", doneq.size(), 1);
      if (doneq.size() > 0) begin
         chk("restart_done_cyc", doneq[0].cyc, ts2 + 64);
         chk("restart_done_ck", doneq[0].data, sum_mem(0));
      end

      // asynchronous reset at address 5
      pulse_start(ts);
      tick(22);
      chk("rst_rdaddr_before", rd_addr, 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", {rd_addr, disp_addr, disp_data, disp_valid, checksum, done, busy}, 0);
      tick(3);
      chk("rst_no_done", doneq.size(), 0);
      chk("rst_cap_count", capq.size(), 5);
      rst_n = 1'b1;
      tick(2);
      chk("rst_idle_after", {busy, checksum, rd_addr}, 0);

      // DWELL=1: one capture per cycle
      for (int i = 0; i < 16; i++) mem1[i] = 8'($urandom_range(0, 255));
      loop1 = 1'b0;
      cap1q.delete();
      done1q.delete();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      ts = cyc;
      tick(20);
      chk_caps("d1", 0, 16, ts, 1, 1);
      chk("d1_cap_total", cap1q.size(), 16);
      chk("d1_done_count", done1q.size(), 1);
      if (done1q.size() > 0) begin
         chk("d1_done_cyc", done1q[0].cyc, ts + 16);
         chk("d1_done_ck", done1q[0].data, sum_mem(1));
      end
      chk("d1_busy_end", busy1, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
